// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
//   state_t          : two-state gate FSM encoding (IDLE / GATE)
//   DEF_CLK_HZ       : default system clock frequency
//   DEF_GATE_CYCLES  : default gate window (one second at DEF_CLK_HZ, so the result is in Hz)
//   gate_cnt_width() : width needed to hold a gate down-counter loaded with gate_cycles-1
package freq_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_GATE_CYCLES = 100_000_000;

    // The down-counter never holds more than gate_cycles-1, so $clog2(gate_cycles) bits suffice.
    function automatic int gate_cnt_width(input int gate_cycles);
        return ($clog2(gate_cycles) < 1) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input into the clk domain and flags its rising edges.
//   clk        : system clock
//   rst        : synchronous, active-low reset (clears all three flops)
//   async_in   : asynchronous input
//   rise_pulse : one clk cycle high per synchronized rising edge of async_in
module sync_edge_det
    import freq_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            // p0/p1: metastability filter; p2: one-cycle history for edge detection
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise_pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a gate window of GATE_CYCLES clk cycles.
// With GATE_CYCLES equal to the clk frequency the result reads directly in Hz.
//   clk        : system clock (only clock)
//   rst        : synchronous, active-low reset
//   start      : one-cycle request for a single measurement, ignored while busy
//   continuous : run back-to-back windows with no gap; sampled on the last window cycle
//   sig_in     : asynchronous signal under measurement
//   busy       : high while a gate window is open
//   freq_valid : one-cycle pulse when freq_out/overflow are updated
//   freq_out   : rising edges counted in the last completed window (held)
//   overflow   : edge count saturated during the last completed window (held)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             sig_in,
    output logic             busy,
    output logic             freq_valid,
    output logic [CNT_W-1:0] freq_out,
    output logic             overflow
);

    localparam int GATE_W = gate_cnt_width(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2) begin : g_bad_gate
        $error("freq_meter: GATE_CYCLES must be at least 2");
    end
    if (CLK_HZ < 1) begin : g_bad_clk
        $error("freq_meter: CLK_HZ must be positive");
    end

    // Saturating edge counter step: returns {overflow flag, count}.
    // An edge arriving while the count is all-ones leaves the count alone and raises the flag.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             flag,
                                               input logic             inc);
        if (!inc) begin
            return {flag, cnt};
        end else if (&cnt) begin
            return {1'b1, cnt};
        end else begin
            return {flag, cnt + CNT_W'(1)};
        end
    endfunction

    state_t             state;
    logic [GATE_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic               ovf;
    logic               edge_det;
    logic [CNT_W-1:0]   edge_cnt_nxt;
    logic               ovf_nxt;

    sync_edge_det u_sync_edge_det (
        .clk        (clk),
        .rst        (rst),
        .async_in   (sig_in),
        .rise_pulse (edge_det)
    );

    always_comb begin
        {ovf_nxt, edge_cnt_nxt} = sat_inc(edge_cnt, ovf, edge_det);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            freq_valid <= 1'b0;
            freq_out   <= '0;
            overflow   <= 1'b0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state    <= GATE;
                        busy     <= 1'b1;
                        gate_cnt <= GATE_LOAD;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                GATE: begin
                    if (gate_cnt == '0) begin
                        // Last window cycle: its own edge is part of the published count.
                        freq_out   <= edge_cnt_nxt;
                        overflow   <= ovf_nxt;
                        freq_valid <= 1'b1;
                        edge_cnt   <= '0;
                        ovf        <= 1'b0;
                        if (continuous) begin
                            // Reload in the same cycle so consecutive windows abut.
                            gate_cnt <= GATE_LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                        edge_cnt <= edge_cnt_nxt;
                        ovf      <= ovf_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a 100-cycle gate window.
// Two instances share all inputs: a 32-bit counter and a 4-bit counter (to reach saturation).
module tb_freq_meter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic        sig_in;

    logic        busy_a, valid_a, ovf_a;
    logic [31:0] freq_a;
    logic        busy_b, valid_b, ovf_b;
    logic [3:0]  freq_b;

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(G), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sig_in(sig_in),
        .busy(busy_a), .freq_valid(valid_a), .freq_out(freq_a), .overflow(ovf_a)
    );

    freq_meter #(.CLK_HZ(100_000_000), .GATE_CYCLES(G), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .sig_in(sig_in),
        .busy(busy_b), .freq_valid(valid_b), .freq_out(freq_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // sig_in generator settings
    int per = 0, hi = 0, ph = 0, rnd_hold = 0;
    bit stuck = 1'b0, rnd_sig = 1'b0;

    // Reference model: samp[e] is the value of sig_in captured by the synchronizer at edge e.
    // A rising edge of the captured sequence is counted two edges later than it is captured.
    bit      samp[$];
    bit      m_open  = 1'b0;
    int      m_k     = 0;
    int      m_cnt   = 0;
    bit      m_busy  = 1'b0;
    bit      m_valid = 1'b0;
    longint  m_freq_a = 0;
    bit      m_ovf_a = 1'b0;
    int      m_freq_b = 0;
    bit      m_ovf_b = 1'b0;

    typedef struct {
        int          per;
        int          hi;
        bit          stk;
        logic [31:0] exp_a;
        logic        exp_oa;
        logic [3:0]  exp_b;
        logic        exp_ob;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit s;
        bit ed;
        int n;
        s = rst ? sig_in : 1'b0;
        samp.push_back(s);
        if (!rst) begin
            n = samp.size();
            for (int i = (n > 3 ? n - 3 : 0); i < n; i++) samp[i] = 1'b0;
            m_open = 1'b0; m_busy = 1'b0; m_valid = 1'b0;
            m_freq_a = 0; m_ovf_a = 1'b0; m_freq_b = 0; m_ovf_b = 1'b0;
            return;
        end
        ed = (cyc >= 3) && samp[cyc-2] && !samp[cyc-3];
        m_valid = 1'b0;
        if (m_open) begin
            m_cnt += int'(ed);
            if (cyc == m_k + G) begin
                m_valid  = 1'b1;
                m_freq_a = m_cnt;
                m_ovf_a  = 1'b0;
                m_freq_b = (m_cnt > 15) ? 15 : m_cnt;
                m_ovf_b  = (m_cnt > 15);
                if (continuous) begin
                    m_k = cyc; m_cnt = 0;
                end else begin
                    m_open = 1'b0;
                end
            end
        end else if (start || continuous) begin
            m_open = 1'b1; m_k = cyc; m_cnt = 0;
        end
        m_busy = m_open;
    endtask

    task automatic tick();
        if (rnd_sig) begin
            if (rnd_hold == 0) begin
                sig_in   = ~sig_in;
                rnd_hold = $urandom_range(0, 6);
            end else begin
                rnd_hold--;
            end
        end else if (per == 0) begin
            sig_in = stuck;
        end else begin
            sig_in = (ph < hi);
            ph     = (ph + 1) % per;
        end
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        chk("busy_a",  busy_a,  m_busy);
        chk("valid_a", valid_a, m_valid);
        chk("freq_a",  freq_a,  m_freq_a);
        chk("ovf_a",   ovf_a,   m_ovf_a);
        chk("busy_b",  busy_b,  m_busy);
        chk("valid_b", valid_b, m_valid);
        chk("freq_b",  freq_b,  m_freq_b);
        chk("ovf_b",   ovf_b,   m_ovf_b);
    endtask

    task automatic set_wave(input int p, input int h, input bit s);
        rnd_sig = 1'b0; per = p; hi = h; stuck = s; ph = 0;
    endtask

    // One start pulse, then observe up to G+20 edges. k is the edge that sampled start.
    task automatic run_window(output int k, output int nvalid, output int nbusy, output int vedge,
                              output logic [31:0] fa, output logic oa,
                              output logic [3:0] fb, output logic ob);
        nvalid = 0; nbusy = 0; vedge = -1;
        fa = 'x; oa = 'x; fb = 'x; ob = 'x;
        start = 1'b1;
        tick();
        k = cyc;
        start = 1'b0;
        if (busy_a === 1'b1) nbusy++;
        for (int i = 0; i < G + 20; i++) begin
            tick();
            if (busy_a === 1'b1) nbusy++;
            if (valid_a === 1'b1) begin
                nvalid++; vedge = cyc;
                fa = freq_a; oa = ovf_a; fb = freq_b; ob = ovf_b;
            end
        end
    endtask

    initial begin
        int k, nv, nb, ve, budget;
        logic [31:0] fa;
        logic [3:0]  fb;
        logic        oa, ob;
        int vedges[3];

        tbl[0] = '{10,  5,  1'b0, 32'd10, 1'b0, 4'd10, 1'b0};
        tbl[1] = '{4,   2,  1'b0, 32'd25, 1'b0, 4'd15, 1'b1};
        tbl[2] = '{20,  10, 1'b0, 32'd5,  1'b0, 4'd5,  1'b0};
        tbl[3] = '{2,   1,  1'b0, 32'd50, 1'b0, 4'd15, 1'b1};
        tbl[4] = '{5,   2,  1'b0, 32'd20, 1'b0, 4'd15, 1'b1};
        tbl[5] = '{100, 50, 1'b0, 32'd1,  1'b0, 4'd1,  1'b0};
        tbl[6] = '{0,   0,  1'b1, 32'd0,  1'b0, 4'd0,  1'b0};

        samp.push_back(1'b0);
        rst = 1'b0; start = 1'b0; continuous = 1'b0; sig_in = 1'b0;

        // Reset held 10 cycles, then idle with a toggling input and no start
        set_wave(6, 3, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("rst_busy",  busy_a,  0);
        chk("rst_valid", valid_a, 0);
        chk("rst_freq",  freq_a,  0);
        chk("rst_ovf",   ovf_a,   0);
        nb = 0;
        repeat (30) begin
            tick();
            if (busy_a !== 1'b0 || valid_a !== 1'b0) nb++;
        end
        chk("idle_quiet", nb, 0);

        // Single-shot measurements from the vector table
        for (int t = 0; t < 7; t++) begin
            set_wave(tbl[t].per, tbl[t].hi, tbl[t].stk);
            repeat (40) tick();
            run_window(k, nv, nb, ve, fa, oa, fb, ob);
            chk("tbl_nvalid", nv, 1);
            chk("tbl_busy_len", nb, G);
            chk("tbl_latency", ve - k, G);
            chk("tbl_freq_a", fa, tbl[t].exp_a);
            chk("tbl_ovf_a",  oa, tbl[t].exp_oa);
            chk("tbl_freq_b", fb, tbl[t].exp_b);
            chk("tbl_ovf_b",  ob, tbl[t].exp_ob);
        end

        // Stuck-high input with a second start pulse mid-window
        set_wave(0, 0, 1'b1);
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (40) tick();
        start = 1'b1; tick(); start = 1'b0;
        nv = 0; fa = 'x;
        for (int i = 0; i < G + 40; i++) begin
            tick();
            if (valid_a === 1'b1) begin nv++; fa = freq_a; end
        end
        chk("restart_nvalid", nv, 1);
        chk("restart_freq", fa, 0);

        // Continuous windows, then drop continuous mid-window
        set_wave(4, 2, 1'b0);
        repeat (40) tick();
        continuous = 1'b1;
        nv = 0; budget = 0;
        while (nv < 3 && budget < 400) begin
            tick();
            budget++;
            if (valid_a === 1'b1) begin
                vedges[nv] = cyc;
                chk("cont_freq", freq_a, 25);
                nv++;
            end
        end
        chk("cont_results", nv, 3);
        if (nv == 3) begin
            chk("cont_gap1", vedges[1] - vedges[0], G);
            chk("cont_gap2", vedges[2] - vedges[1], G);
        end
        repeat (50) tick();
        continuous = 1'b0;
        nv = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (valid_a === 1'b1) nv++;
        end
        chk("cont_drop_nvalid", nv, 1);
        chk("cont_drop_idle", busy_a, 0);

        // Reset in the middle of a window
        set_wave(10, 5, 1'b0);
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (50) tick();
        rst = 1'b0; tick(); rst = 1'b1;
        chk("midrst_busy",  busy_a,  0);
        chk("midrst_valid", valid_a, 0);
        chk("midrst_freq",  freq_a,  0);
        chk("midrst_ovf",   ovf_a,   0);
        chk("midrst_freq_b", freq_b, 0);
        nv = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (valid_a === 1'b1) nv++;
        end
        chk("midrst_no_valid", nv, 0);
        run_window(k, nv, nb, ve, fa, oa, fb, ob);
        chk("postrst_nvalid", nv, 1);
        chk("postrst_freq", fa, 10);

        // Randomized traffic checked cycle by cycle against the model
        rnd_sig = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) continuous = ~continuous;
            rst = ($urandom_range(0, 1499) != 0);
            tick();
        end
        rst = 1'b1; start = 1'b0; continuous = 1'b0;
        repeat (G + 10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
